// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter; the grant is held for a whole CYC so bursts are never split.
// Optional stalled-beat timeout is built when the macro WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter_2m #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                s0_wb_cyc_i,
  input  logic                s0_wb_stb_i,
  input  logic                s0_wb_we_i,
  input  logic [ADDR_W-1:0]   s0_wb_adr_i,
  input  logic [DATA_W-1:0]   s0_wb_dat_i,
  input  logic [DATA_W/8-1:0] s0_wb_sel_i,
  output logic [DATA_W-1:0]   s0_wb_dat_o,
  output logic                s0_wb_ack_o,
  output logic                s0_wb_err_o,
  input  logic                s1_wb_cyc_i,
  input  logic                s1_wb_stb_i,
  input  logic                s1_wb_we_i,
  input  logic [ADDR_W-1:0]   s1_wb_adr_i,
  input  logic [DATA_W-1:0]   s1_wb_dat_i,
  input  logic [DATA_W/8-1:0] s1_wb_sel_i,
  output logic [DATA_W-1:0]   s1_wb_dat_o,
  output logic                s1_wb_ack_o,
  output logic                s1_wb_err_o,
  output logic                m_wb_cyc_o,
  output logic                m_wb_stb_o,
  output logic                m_wb_we_o,
  output logic [ADDR_W-1:0]   m_wb_adr_o,
  output logic [DATA_W-1:0]   m_wb_dat_o,
  output logic [DATA_W/8-1:0] m_wb_sel_o,
  input  logic [DATA_W-1:0]   m_wb_dat_i,
  input  logic                m_wb_ack_i,
  input  logic                m_wb_err_i,
  output logic [1:0]          o_grant
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e state_q, state_d;
  logic   lastGrant_q, lastGrant_d;
  logic   rawStb;
  logic   timeoutHit;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // On a tie the master that did not own the bus last time wins.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (s0_wb_cyc_i && s1_wb_cyc_i) state_d = lastGrant_q ? GNT0 : GNT1;
        else if (s0_wb_cyc_i)           state_d = GNT0;
        else if (s1_wb_cyc_i)           state_d = GNT1;
      end
      GNT0: begin
        if (!s0_wb_cyc_i) begin
          state_d     = IDLE;
          lastGrant_d = 1'b0;
        end
      end
      GNT1: begin
        if (!s1_wb_cyc_i) begin
          state_d     = IDLE;
          lastGrant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rawStb = (state_q == GNT0) ? s0_wb_stb_i :
                  (state_q == GNT1) ? s1_wb_stb_i : 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  logic [15:0] stallCnt_q, stallCnt_d;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) stallCnt_q <= '0;
    else           stallCnt_q <= stallCnt_d;
  end

  assign timeoutHit = rawStb && (stallCnt_q == TimeoutLimit);

  always_comb begin
    stallCnt_d = stallCnt_q + 16'd1;
    if (timeoutHit || (state_d != state_q) || !rawStb || m_wb_ack_i || m_wb_err_i)
      stallCnt_d = '0;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Outputs are purely combinational from the registered grant, so response paths add no latency.
  always_comb begin
    m_wb_cyc_o  = 1'b0;
    m_wb_stb_o  = 1'b0;
    m_wb_we_o   = 1'b0;
    m_wb_adr_o  = '0;
    m_wb_dat_o  = '0;
    m_wb_sel_o  = '0;
    s0_wb_dat_o = '0;
    s0_wb_ack_o = 1'b0;
    s0_wb_err_o = 1'b0;
    s1_wb_dat_o = '0;
    s1_wb_ack_o = 1'b0;
    s1_wb_err_o = 1'b0;
    o_grant     = 2'b00;
    case (state_q)
      GNT0: begin
        m_wb_cyc_o  = s0_wb_cyc_i;
        m_wb_stb_o  = s0_wb_stb_i & ~timeoutHit;
        m_wb_we_o   = s0_wb_we_i;
        m_wb_adr_o  = s0_wb_adr_i;
        m_wb_dat_o  = s0_wb_dat_i;
        m_wb_sel_o  = s0_wb_sel_i;
        s0_wb_dat_o = m_wb_dat_i;
        s0_wb_ack_o = m_wb_ack_i & ~timeoutHit;
        s0_wb_err_o = m_wb_err_i | timeoutHit;
        o_grant     = 2'b01;
      end
      GNT1: begin
        m_wb_cyc_o  = s1_wb_cyc_i;
        m_wb_stb_o  = s1_wb_stb_i & ~timeoutHit;
        m_wb_we_o   = s1_wb_we_i;
        m_wb_adr_o  = s1_wb_adr_i;
        m_wb_dat_o  = s1_wb_dat_i;
        m_wb_sel_o  = s1_wb_sel_i;
        s1_wb_dat_o = m_wb_dat_i;
        s1_wb_ack_o = m_wb_ack_i & ~timeoutHit;
        s1_wb_err_o = m_wb_err_i | timeoutHit;
        o_grant     = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
